pipe_exmem_hazard: RTL and testbench
====================================

Name: pipe_exmem_hazard

Overview:
- Middle of the 5-stage MIPS-like pipeline. Contains the ID/EX pipeline register, the EX/MEM pipeline register and the hazard-control logic.
- Captures decoded ID-stage fields and the EX-stage ALU result.
- Detects RAW hazards and taken jumps/branches, and drives stall and flush controls to the PC and IF/ID stages.
- There is no forwarding. The register file is write-before-read, so a WB-stage write is visible in ID in the same cycle.

Parameters:
DWIDTH, 32, datapath width

Ports:
clk  input  1  clock, all registers update on rising edge
rst  input  1  synchronous active-high reset
id_pc  input  DWIDTH  PC of the instruction in ID
id_jump_addr  input  26  J/JAL target field
id_imm  input  DWIDTH  sign-extended immediate
id_rs1  input  DWIDTH  register-file read data, port 1
id_rs2  input  DWIDTH  register-file read data, port 2
id_rs1_id  input  5  source register index 1
id_rs2_id  input  5  source register index 2
id_rdst_id  input  5  destination register index
id_ctrl  input  12  {op[3:0], we_dmem, we_reg, wbsel[1:0], ssel, jump_type[2:0]}
ex_alu_out  input  DWIDTH  ALU result in EX
ex_zero  input  1  ALU zero flag in EX
ex_pc  output  DWIDTH  registered id_pc
ex_jump_addr  output  32  registered id_jump_addr, zero-extended
ex_imm  output  DWIDTH  registered id_imm
ex_rs1  output  DWIDTH  registered id_rs1
ex_rs2  output  DWIDTH  registered id_rs2
ex_rdst_id  output  5  registered id_rdst_id
ex_ctrl  output  12  registered id_ctrl, same field layout
mem_rd  output  DWIDTH  registered ex_alu_out
mem_rs2  output  DWIDTH  registered ex_rs2 (store data)
mem_rdst_id  output  5  registered ex_rdst_id
mem_ctrl  output  4  registered {we_dmem, we_reg, wbsel[1:0]} taken from ex_ctrl
pc_write  output  1  1 = PC may advance
ifid_write  output  1  1 = IF/ID register may load
ifid_flush  output  1  1 = IF/ID register must load a bubble

Behaviour:
- jump_type encoding: 0 NOP, 1 BEQ, 2 JAL, 3 JR, 4 J.
- wbsel encoding: 0 ALU, 1 dmem, 2 PC+4.
- Reset (rst=1 at posedge): every ID/EX and EX/MEM register clears to 0. This includes ex_* and mem_* outputs.
- Hazard outputs are purely combinational from current register state and ID inputs. With all registers cleared they read pc_write=1, ifid_write=1, ifid_flush=0.
- redirect = (ex jump_type in {JAL, JR, J}) OR (ex jump_type == BEQ AND ex_zero).
- raw_ex = ex we_reg AND ex_rdst_id != 0 AND (ex_rdst_id == id_rs1_id OR ex_rdst_id == id_rs2_id).
- raw_mem = mem we_reg AND mem_rdst_id != 0 AND it matches id_rs1_id or id_rs2_id.
- stall = (raw_ex OR raw_mem) AND NOT redirect. Both source indices are always compared, which is conservative.
- When redirect: pc_write=1, ifid_write=1, ifid_flush=1, and the ID/EX register loads a bubble at the next edge. The wrong-path instructions in IF and ID are squashed, giving a 2-cycle taken penalty. Redirect has priority over stall.
- When stall: pc_write=0, ifid_write=0, ifid_flush=0, and ID/EX loads a bubble. The stall repeats every cycle until the producer has left MEM: up to 2 bubbles behind EX, 1 bubble behind MEM.
- Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, and ID/EX loads the ID inputs.
- Bubble: all ID/EX fields are 0, so ctrl=0 (NOP, no writes, op 0), all data is 0 and rdst_id is 0.
- EX/MEM loads every non-reset cycle with no stall or flush. Bubbles propagate naturally.
- 1-cycle latency per register. ex_* outputs are valid the cycle after capture; mem_* outputs one cycle later.
- Simultaneous rst and hazard: reset wins, and the registers clear.

Test Plan:
- Reset: hold rst 2 cycles, then release -> all ex_*/mem_* = 0; pc_write=1, ifid_write=1, ifid_flush=0.
- Pass-through: ID addi r2 (ctrl op=2, we_reg=1, rdst=2, imm=5, pc=0x10) with no hazard -> next edge ex_imm=5, ex_pc=0x10. Then drive ex_alu_out=7 -> the following edge gives mem_rd=7, mem_rdst_id=2, mem_ctrl=0b0100.
- RAW stall: EX holds we_reg=1 rdst=3 while ID has rs1_id=3 -> pc_write=0, ifid_write=0, and ex_ctrl=0 next edge. The stall persists 2 cycles in total, then releases.
- rd=0 immunity: EX holds we_reg=1 rdst=0 while ID has rs1_id=0 -> no stall.
- BEQ taken: ex jump_type=1 with ex_zero=1 -> ifid_flush=1, pc_write=1, and ex_ctrl=0 next edge. With ex_zero=0 -> ifid_flush=0.
- J while a RAW is pending: ex jump_type=4, id_rs1 matches mem_rdst_id -> redirect wins: ifid_flush=1, pc_write=1. The ex_jump_addr of the J equals its 26-bit field zero-extended.

Source files
------------

// File: rtl/pipe_exmem_hazard.sv
// ID/EX and EX/MEM pipeline registers with the RAW-stall / redirect-flush control.
// There is no forwarding: a consumer waits in ID until its producer has left MEM.
module pipe_exmem_hazard #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] id_pc,
  input  logic [25:0]       id_jump_addr,
  input  logic [DWIDTH-1:0] id_imm,
  input  logic [DWIDTH-1:0] id_rs1,
  input  logic [DWIDTH-1:0] id_rs2,
  input  logic [4:0]        id_rs1_id,
  input  logic [4:0]        id_rs2_id,
  input  logic [4:0]        id_rdst_id,
  input  logic [11:0]       id_ctrl,
  input  logic [DWIDTH-1:0] ex_alu_out,
  input  logic              ex_zero,
  output logic [DWIDTH-1:0] ex_pc,
  output logic [31:0]       ex_jump_addr,
  output logic [DWIDTH-1:0] ex_imm,
  output logic [DWIDTH-1:0] ex_rs1,
  output logic [DWIDTH-1:0] ex_rs2,
  output logic [4:0]        ex_rdst_id,
  output logic [11:0]       ex_ctrl,
  output logic [DWIDTH-1:0] mem_rd,
  output logic [DWIDTH-1:0] mem_rs2,
  output logic [4:0]        mem_rdst_id,
  output logic [3:0]        mem_ctrl,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush
);

  localparam logic [2:0] JT_BEQ = 3'd1;
  localparam logic [2:0] JT_JAL = 3'd2;
  localparam logic [2:0] JT_JR  = 3'd3;
  localparam logic [2:0] JT_J   = 3'd4;

  logic [DWIDTH-1:0] ex_pc_q, ex_imm_q, ex_rs1_q, ex_rs2_q;
  logic [31:0]       ex_jump_addr_q;
  logic [4:0]        ex_rdst_q;
  logic [11:0]       ex_ctrl_q;
  logic [DWIDTH-1:0] mem_rd_q, mem_rs2_q;
  logic [4:0]        mem_rdst_q;
  logic [3:0]        mem_ctrl_q;

  logic [2:0] ex_jt;
  logic       ex_we_reg, mem_we_reg;
  logic       redirect, raw_ex, raw_mem, stall, bubble;

  assign ex_jt      = ex_ctrl_q[2:0];
  assign ex_we_reg  = ex_ctrl_q[6];
  assign mem_we_reg = mem_ctrl_q[2];

  always_comb begin
    redirect = (ex_jt == JT_JAL) || (ex_jt == JT_JR) || (ex_jt == JT_J) ||
               ((ex_jt == JT_BEQ) && ex_zero);
    raw_ex   = ex_we_reg && (ex_rdst_q != 5'd0) &&
               ((ex_rdst_q == id_rs1_id) || (ex_rdst_q == id_rs2_id));
    raw_mem  = mem_we_reg && (mem_rdst_q != 5'd0) &&
               ((mem_rdst_q == id_rs1_id) || (mem_rdst_q == id_rs2_id));
    // Redirect squashes the waiting consumer anyway, so it overrides the stall.
    stall    = (raw_ex || raw_mem) && !redirect;
    bubble   = stall || redirect;
  end

  assign pc_write   = !stall;
  assign ifid_write = !stall;
  assign ifid_flush = redirect;

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_pc_q        <= '0;
      ex_jump_addr_q <= '0;
      ex_imm_q       <= '0;
      ex_rs1_q       <= '0;
      ex_rs2_q       <= '0;
      ex_rdst_q      <= '0;
      ex_ctrl_q      <= '0;
    end else begin
      ex_pc_q        <= id_pc;
      ex_jump_addr_q <= {6'd0, id_jump_addr};
      ex_imm_q       <= id_imm;
      ex_rs1_q       <= id_rs1;
      ex_rs2_q       <= id_rs2;
      ex_rdst_q      <= id_rdst_id;
      ex_ctrl_q      <= id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_rd_q   <= '0;
      mem_rs2_q  <= '0;
      mem_rdst_q <= '0;
      mem_ctrl_q <= '0;
    end else begin
      mem_rd_q   <= ex_alu_out;
      mem_rs2_q  <= ex_rs2_q;
      mem_rdst_q <= ex_rdst_q;
      mem_ctrl_q <= ex_ctrl_q[7:4];
    end
  end

  assign ex_pc        = ex_pc_q;
  assign ex_jump_addr = ex_jump_addr_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rs1       = ex_rs1_q;
  assign ex_rs2       = ex_rs2_q;
  assign ex_rdst_id   = ex_rdst_q;
  assign ex_ctrl      = ex_ctrl_q;
  assign mem_rd       = mem_rd_q;
  assign mem_rs2      = mem_rs2_q;
  assign mem_rdst_id  = mem_rdst_q;
  assign mem_ctrl     = mem_ctrl_q;

endmodule

// File: tb/tb_pipe_exmem_hazard.sv
// Directed bench for pipe_exmem_hazard: reset, pass-through, RAW stall, rd=0, BEQ, J over a RAW.
module tb_pipe_exmem_hazard;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_pc, id_imm, id_rs1, id_rs2, ex_alu_out;
  logic [25:0] id_jump_addr;
  logic [4:0]  id_rs1_id, id_rs2_id, id_rdst_id;
  logic [11:0] id_ctrl;
  logic        ex_zero;
  logic [31:0] ex_pc, ex_jump_addr, ex_imm, ex_rs1, ex_rs2, mem_rd, mem_rs2;
  logic [4:0]  ex_rdst_id, mem_rdst_id;
  logic [11:0] ex_ctrl;
  logic [3:0]  mem_ctrl;
  logic        pc_write, ifid_write, ifid_flush;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_exmem_hazard #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .id_pc(id_pc), .id_jump_addr(id_jump_addr), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_id(id_rs1_id), .id_rs2_id(id_rs2_id), .id_rdst_id(id_rdst_id),
    .id_ctrl(id_ctrl), .ex_alu_out(ex_alu_out), .ex_zero(ex_zero),
    .ex_pc(ex_pc), .ex_jump_addr(ex_jump_addr), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rdst_id(ex_rdst_id), .ex_ctrl(ex_ctrl),
    .mem_rd(mem_rd), .mem_rs2(mem_rs2), .mem_rdst_id(mem_rdst_id), .mem_ctrl(mem_ctrl),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [11:0] ctrl, input logic [4:0] rdst,
                          input logic [4:0] rs1i, input logic [4:0] rs2i,
                          input logic [31:0] pc);
    id_ctrl    = ctrl;
    id_rdst_id = rdst;
    id_rs1_id  = rs1i;
    id_rs2_id  = rs2i;
    id_pc      = pc;
  endtask

  task automatic check_hz(input string tag, input logic pw, input logic iw, input logic fl);
    check({tag, ".pc_write"},   {31'd0, pc_write},   {31'd0, pw});
    check({tag, ".ifid_write"}, {31'd0, ifid_write}, {31'd0, iw});
    check({tag, ".ifid_flush"}, {31'd0, ifid_flush}, {31'd0, fl});
  endtask

  initial begin
    // Non-zero ID inputs during reset: the registers must still clear.
    rst = 1'b1;
    id_pc = 32'hDEAD; id_imm = 32'h1234; id_rs1 = 32'h11; id_rs2 = 32'h22;
    id_jump_addr = 26'h155; id_rs1_id = 5'd0; id_rs2_id = 5'd0; id_rdst_id = 5'd4;
    id_ctrl = 12'h2C4; ex_alu_out = 32'h99; ex_zero = 1'b0;
    tick(); tick();
    check("rst.ex_pc", ex_pc, 32'h0);
    check("rst.ex_ctrl", {20'd0, ex_ctrl}, 32'h0);
    check("rst.ex_imm", ex_imm, 32'h0);
    check("rst.mem_rd", mem_rd, 32'h0);
    check("rst.mem_ctrl", {28'd0, mem_ctrl}, 32'h0);
    check_hz("rst", 1'b1, 1'b1, 1'b0);

    rst = 1'b0;
    id_imm = 32'd0; id_rs1 = 32'd0; id_rs2 = 32'd0; id_jump_addr = 26'd0; ex_alu_out = 32'd0;
    drive_id(12'h000, 5'd0, 5'd0, 5'd0, 32'd0);
    tick();
    check("rel.ex_rdst", {27'd0, ex_rdst_id}, 32'h0);
    check_hz("rel", 1'b1, 1'b1, 1'b0);

    // Pass-through: addi r2
    drive_id(12'h240, 5'd2, 5'd1, 5'd0, 32'h10);
    id_imm = 32'd5; id_rs1 = 32'h55; id_rs2 = 32'hAA;
    #1 check_hz("addi", 1'b1, 1'b1, 1'b0);
    tick();
    check("pt.ex_imm", ex_imm, 32'd5);
    check("pt.ex_pc", ex_pc, 32'h10);
    check("pt.ex_ctrl", {20'd0, ex_ctrl}, 32'h240);
    check("pt.ex_rdst", {27'd0, ex_rdst_id}, 32'd2);
    check("pt.ex_rs1", ex_rs1, 32'h55);
    drive_id(12'h000, 5'd0, 5'd0, 5'd0, 32'd0);
    id_imm = 32'd0; id_rs1 = 32'd0; id_rs2 = 32'd0;
    ex_alu_out = 32'd7;
    tick();
    check("pt.mem_rd", mem_rd, 32'd7);
    check("pt.mem_rdst", {27'd0, mem_rdst_id}, 32'd2);
    check("pt.mem_ctrl", {28'd0, mem_ctrl}, 32'h4);
    check("pt.mem_rs2", mem_rs2, 32'hAA);
    check("pt.ex_nop", {20'd0, ex_ctrl}, 32'h0);
    ex_alu_out = 32'd0;
    tick();

    // RAW stall: producer r3 enters EX, consumer reads r3 in ID
    drive_id(12'h040, 5'd3, 5'd0, 5'd0, 32'h1C);
    tick();
    drive_id(12'h100, 5'd6, 5'd3, 5'd0, 32'h20);
    #1 check_hz("raw_ex", 1'b0, 1'b0, 1'b0);
    tick();
    check("raw.bubble1_ctrl", {20'd0, ex_ctrl}, 32'h0);
    check("raw.bubble1_pc", ex_pc, 32'h0);
    check("raw.mem_rdst", {27'd0, mem_rdst_id}, 32'd3);
    check_hz("raw_mem", 1'b0, 1'b0, 1'b0);
    tick();
    check("raw.bubble2_ctrl", {20'd0, ex_ctrl}, 32'h0);
    check_hz("raw_rel", 1'b1, 1'b1, 1'b0);
    tick();
    check("raw.consumer_pc", ex_pc, 32'h20);
    check("raw.consumer_ctrl", {20'd0, ex_ctrl}, 32'h100);

    // rd=0 immunity
    drive_id(12'h040, 5'd0, 5'd0, 5'd0, 32'h24);
    tick();
    drive_id(12'h100, 5'd1, 5'd0, 5'd0, 32'h28);
    #1 check_hz("rd0", 1'b1, 1'b1, 1'b0);

    // BEQ taken
    drive_id(12'h001, 5'd0, 5'd0, 5'd0, 32'h2C);
    tick();
    drive_id(12'h240, 5'd5, 5'd0, 5'd0, 32'h30);
    ex_zero = 1'b1;
    #1 check_hz("beq_taken", 1'b1, 1'b1, 1'b1);
    tick();
    check("beq.squash_ctrl", {20'd0, ex_ctrl}, 32'h0);
    check("beq.squash_pc", ex_pc, 32'h0);

    // BEQ not taken
    ex_zero = 1'b0;
    drive_id(12'h001, 5'd0, 5'd0, 5'd0, 32'h40);
    tick();
    drive_id(12'h240, 5'd5, 5'd0, 5'd0, 32'h44);
    #1 check_hz("beq_nt", 1'b1, 1'b1, 1'b0);
    tick();
    check("beq_nt.ex_pc", ex_pc, 32'h44);

    // J while a RAW on the MEM producer is pending in ID
    drive_id(12'h040, 5'd7, 5'd0, 5'd0, 32'h50);
    tick();
    drive_id(12'h004, 5'd0, 5'd0, 5'd0, 32'h54);
    id_jump_addr = 26'h3ABCDEF;
    tick();
    id_jump_addr = 26'd0;
    drive_id(12'h100, 5'd8, 5'd7, 5'd0, 32'h58);
    #1;
    check("j.mem_rdst", {27'd0, mem_rdst_id}, 32'd7);
    check("j.ex_jump_addr", ex_jump_addr, 32'h03ABCDEF);
    check_hz("j_raw", 1'b1, 1'b1, 1'b1);
    tick();
    check("j.squash_ctrl", {20'd0, ex_ctrl}, 32'h0);

    // Reset while a stall is active
    drive_id(12'h040, 5'd9, 5'd0, 5'd0, 32'h60);
    tick();
    drive_id(12'h100, 5'd1, 5'd9, 5'd0, 32'h64);
    #1 check_hz("pre_rst_stall", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("rst_hz.ex_ctrl", {20'd0, ex_ctrl}, 32'h0);
    check("rst_hz.mem_rdst", {27'd0, mem_rdst_id}, 32'd0);
    check("rst_hz.mem_ctrl", {28'd0, mem_ctrl}, 32'd0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
